// File: rtl/alu_design.sv
// Integer ALU leaf execution unit with a single registered result stage.
// Operands and opcode are captured on an accepted cycle; result and status
// flags appear one clock later. Outputs are driven only from registers.
module alu_design #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             op_err
);

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpShl  = 4'd5,
        OpShr  = 4'd6,
        OpSar  = 4'd7,
        OpEq   = 4'd8
    } alu_op_e;

    // WIDTH always fits in WIDTH bits for WIDTH >= 2, so B can be compared directly.
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    // Next-state values for the result stage
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             overflow_d;
    logic             op_err_d;
    logic             zero_d;

    // Registered state
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             overflow_q;
    logic             op_err_q;
    logic             zero_q;
    logic             valid_q;

    // Shared arithmetic with an extra bit to expose carry/borrow
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             shift_big;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] sar_res;

    // Adder, subtractor and shift-range detect
    always_comb begin
        sum_ext   = {1'b0, A} + {1'b0, B};
        diff_ext  = {1'b0, A} - {1'b0, B};
        shift_big = (B >= SHIFT_LIMIT);
        a_msb     = A[WIDTH-1];
        b_msb     = B[WIDTH-1];
        sar_res   = $unsigned($signed(A) >>> B[WIDTH-1:0]);
    end

    // Opcode decode and result/flag selection
    always_comb begin
        res_d      = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        op_err_d   = 1'b0;

        case (op)
            OpAdd: begin
                res_d      = sum_ext[WIDTH-1:0];
                carry_d    = sum_ext[WIDTH];
                overflow_d = (a_msb == b_msb) && (sum_ext[WIDTH-1] != a_msb);
            end
            OpSub: begin
                res_d      = diff_ext[WIDTH-1:0];
                // Top bit of the widened difference is set exactly when A < B unsigned.
                carry_d    = diff_ext[WIDTH];
                overflow_d = (a_msb != b_msb) && (diff_ext[WIDTH-1] != a_msb);
            end
            OpAnd: res_d = A & B;
            OpOr:  res_d = A | B;
            OpXor: res_d = A ^ B;
            OpShl: begin
                if (shift_big) begin
                    res_d = '0;
                end else begin
                    res_d = A << B;
                end
            end
            OpShr: begin
                if (shift_big) begin
                    res_d = '0;
                end else begin
                    res_d = A >> B;
                end
            end
            OpSar: begin
                if (shift_big) begin
                    res_d = {WIDTH{a_msb}};
                end else begin
                    res_d = sar_res;
                end
            end
            OpEq: begin
                res_d = {{(WIDTH-1){1'b0}}, (A == B)};
            end
            default: begin
                res_d    = '0;
                op_err_d = 1'b1;
            end
        endcase

        zero_d = (res_d == '0);
    end

    // Result stage: reset clears everything, idle cycles hold the last result.
    // zero is registered alongside the result so it reads 0 out of reset
    // while still tracking out == 0 for every accepted operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            op_err_q   <= 1'b0;
            zero_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q      <= res_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
                op_err_q   <= op_err_d;
                zero_q     <= zero_d;
            end
        end
    end

    // Output drive straight from registers
    always_comb begin
        out_valid = valid_q;
        out       = res_q;
        zero      = zero_q;
        carry     = carry_q;
        negative  = res_q[WIDTH-1];
        overflow  = overflow_q;
        op_err    = op_err_q;
    end

endmodule

// File: tb/tb_alu_design.sv
module tb_alu_design;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       op;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
    logic             op_err;

    int tests;
    int fails;

    alu_design #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .overflow  (overflow),
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e_out;
        logic       e_c;
        logic       e_v;
        logic       e_z;
        logic       e_n;
        logic       e_err;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_vld, input logic [7:0] e_out,
                             input logic e_c, input logic e_v, input logic e_z,
                             input logic e_n, input logic e_err);
        check({tag, ".valid"}, 32'(out_valid), 32'(e_vld));
        check({tag, ".out"},   32'(out),       32'(e_out));
        check({tag, ".carry"}, 32'(carry),     32'(e_c));
        check({tag, ".ovf"},   32'(overflow),  32'(e_v));
        check({tag, ".zero"},  32'(zero),      32'(e_z));
        check({tag, ".neg"},   32'(negative),  32'(e_n));
        check({tag, ".err"},   32'(op_err),    32'(e_err));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 after the rising edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] o,
                         input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        op       = o;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 4'd0;
        A        = '0;
        B        = '0;

        //            op     a      b      out    c     v     z     n     err
        vecs[0]  = '{4'd0, 8'd10, 8'd5,  8'd15,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'd0, 8'hFF, 8'h01, 8'h00,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'd0, 8'h7F, 8'h01, 8'h80,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'd0, 8'hFF, 8'hFF, 8'hFE,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'd1, 8'd10, 8'd5,  8'd5,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'd1, 8'd5,  8'd10, 8'hFB,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'd1, 8'h80, 8'h01, 8'h7F,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'd1, 8'h00, 8'h00, 8'h00,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'd2, 8'h0F, 8'hF0, 8'h00,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'd3, 8'h0F, 8'hF0, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'd4, 8'hAA, 8'h55, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'd5, 8'd10, 8'd2,  8'd40,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'd6, 8'd128, 8'd1, 8'd64,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'd7, 8'd128, 8'd1, 8'd192, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{4'd7, 8'h80, 8'd9,  8'hFF,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{4'd5, 8'h01, 8'd8,  8'h00,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{4'd6, 8'hF0, 8'hFF, 8'h00,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{4'd7, 8'h70, 8'd200, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{4'd5, 8'hA5, 8'd0,  8'hA5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{4'd7, 8'h81, 8'd7,  8'hFF,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{4'd8, 8'd50, 8'd50, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{4'd8, 8'd25, 8'd30, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{4'd12, 8'd3, 8'd4,  8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[23] = '{4'd15, 8'hFF, 8'hFF, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset for two cycles with in_valid high: reset must win.
        drive(1'b1, 1'b1, 4'd0, 8'd7, 8'd9);
        drive(1'b1, 1'b1, 4'd0, 8'd7, 8'd9);
        check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table applied back-to-back, one accepted op per cycle.
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            check_all($sformatf("vec%0d", i), 1'b1, vecs[i].e_out, vecs[i].e_c,
                      vecs[i].e_v, vecs[i].e_z, vecs[i].e_n, vecs[i].e_err);
        end

        // Idle cycle after a flag-rich result: everything held, out_valid drops.
        drive(1'b0, 1'b1, 4'd0, 8'hFF, 8'h01);
        check_all("hold_pre", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 8'h01, 8'h01);
        check_all("hold1", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd13, 8'h7F, 8'h01);
        check_all("hold2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Error flag clears on the next defined op.
        drive(1'b0, 1'b1, 4'd9, 8'h12, 8'h34);
        check_all("err_set", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'd3, 8'h12, 8'h34);
        check_all("err_clr", 1'b1, 8'h36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset while valid is asserted.
        drive(1'b0, 1'b1, 4'd1, 8'd5, 8'd10);
        check_all("pre_rst", 1'b1, 8'hFB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 4'd1, 8'd5, 8'd10);
        check_all("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd4, 8'h3C, 8'h0F);
        check_all("post_rst", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
